sia_receiver_v2: RTL and testbench
==================================

Name: sia_receiver_v2

Overview:
Parametrised successor V.4-style bit-serial receiver for the SIA peripheral. It adds:
- input synchronisers
- an explicit frame state machine with start-bit validation and stop-bit framing check
- LSB/MSB-first selection and right-justified output
- a valid/ready output handshake with overrun flagging, replacing the free-running shift-register output

It sits between the RXD/RXC pads and the receiver FIFO / Wishbone register block.

Parameters:
DATA_WIDTH, 16, width of dat_o and maximum data bits per frame
BAUD_WIDTH, 32, width of baud_i and the sample counter
BITS_WIDTH, 5, width of bits_i
SYNC_STAGES, 2, synchroniser flops on rxd_i/rxc_i (minimum 2)

Ports:
clk_i  in  1  single system clock
reset_ni  in  1  asynchronous, active-low reset
bits_i  in  BITS_WIDTH  data bits per frame; 0 = receiver disabled
baud_i  in  BAUD_WIDTH  bit period minus one, in clk_i cycles
eedd_i  in  1  resync on any synchronised RXD edge
eedc_i  in  1  resync on synchronised RXC rising edge
msbf_i  in  1  1 = MSB received first
rxd_i  in  1  serial data, asynchronous
rxc_i  in  1  serial clock, asynchronous
dat_o  out  DATA_WIDTH  received word, right-justified, upper bits zero
valid_o  out  1  dat_o holds an unaccepted word
ready_i  in  1  consumer accepts word when valid_o & ready_i
ferr_o  out  1  framing error, qualifies dat_o
ovr_o  out  1  overrun, qualifies dat_o
idle_o  out  1  FSM in IDLE
sample_to  out  1  test: pulses on each sampling cycle

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; dat_o=0, valid_o=0, ferr_o=0, ovr_o=0.
  - Sample counter = 0.
  - rxd synchronisers = 1, rxc synchronisers = 0.
  - Reset mid-frame discards the partial frame and any held word.
- Synchronisation: all logic uses the last synchroniser stage. Edges are detected against one further registered copy.
- Latching: N = min(bits_i, DATA_WIDTH), baud_i and msbf_i are latched on IDLE->START. Mid-frame changes are ignored.
- IDLE:
  - If N != 0 and a falling RXD edge occurs: go to START, counter = baud_i>>1.
  - bits_i == 0: remain in IDLE regardless of line activity.
- Counter:
  - Each cycle in START/DATA/STOP: if counter==0, sample (sample_to=1) and reload latched baud; else decrement.
  - Bit period is baud+1 cycles. baud_i=0 gives one sample per cycle.
- Resync: edge = (eedd_i & RXD any edge) | (eedc_i & RXC rise). In START/DATA/STOP an edge sets counter = baud>>1. Edge has priority over a same-cycle sample, and that sample is skipped.
- START: on sample, RXD=1 is a false start -> IDLE with no output. RXD=0 -> DATA.
- DATA:
  - Shift the sampled bit in: LSB-first enters at bit N-1 and shifts right; MSB-first enters at bit 0 and shifts left.
  - After the N-th sample -> STOP.
- STOP:
  - On sample: ferr = ~RXD.
  - Frame completes: load dat_o and ferr_o; go to IDLE the same cycle.
  - A falling edge on the next cycle may start a new frame.
- Output handshake, on frame completion:
  - valid_o=0: load word, set valid_o, ovr_o=0.
  - valid_o=1 & ready_i=1: old word accepted, new word loaded, valid_o stays 1, ovr_o=0.
  - valid_o=1 & ready_i=0: overwrite word, ovr_o=1.
  - With no completion, valid_o & ready_i clears valid_o, ferr_o and ovr_o next cycle.
- dat_o, ferr_o and ovr_o are stable while valid_o=1 and no completion occurs.

Optional Feature:
SIA_RX_PARITY_EN
- Defined:
  - Adds ports parity_en_i, parity_odd_i (latched with bits_i) and perr_o.
  - When enabled, a PARITY state sits between DATA and STOP and samples one bit.
  - perr_o=1 when XOR(data, parity bit) != parity_odd_i. perr_o follows the same load/clear rules as ferr_o.
- Undefined: ports and state absent; DATA goes directly to STOP.

Decomposition:
- Shared package sia_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP) and the synchroniser reset-level constants.
- Sub-module sia_sync: a SYNC_STAGES-deep synchroniser with a reset-value parameter, instantiated for rxd and rxc.

Test Plan:
- baud_i=9, bits_i=8, msbf_i=0, ready_i=1, send 0xA5 with stop=1 -> dat_o=0x00A5, valid_o for 1 cycle, ferr_o=0, samples 10 cycles apart.
- Same frame with msbf_i=1 -> dat_o=0x00A5 from the MSB-first stream; and with stop bit=0 -> ferr_o=1.
- RXD low for 3 cycles with baud_i=9 -> false start, back to IDLE, valid_o stays 0.
- ready_i=0, two frames 0x11 then 0x22 -> dat_o=0x22, ovr_o=1; raising ready_i clears valid_o and ovr_o next cycle.
- bits_i=0 with RXD toggling -> idle_o=1 throughout; reset_ni pulsed mid-DATA -> all outputs 0 immediately, no word.
- eedd_i=1 with RXD edges drifting 3 cycles late -> counter reloads to 4 at each edge, correct word received; bits_i=20 -> clamped to 16.

Source files
------------

// File: rtl/sia_pkg.sv
// Shared definitions for the SIA bit-serial receiver: frame FSM encoding and
// synchroniser reset levels (the line idles with RXD high, RXC low).
package sia_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic RXD_RST = 1'b1;
  localparam logic RXC_RST = 1'b0;

endpackage

// File: rtl/sia_receiver_v2_if.sv
// Output word handshake of the SIA receiver. perr_o only exists when
// SIA_RX_PARITY_EN is defined.
interface sia_receiver_v2_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] dat_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  ferr_o;
  logic                  ovr_o;
`ifdef SIA_RX_PARITY_EN
  logic                  perr_o;
`endif

  modport master (
    input  ready_i,
    output dat_o, valid_o, ferr_o, ovr_o
`ifdef SIA_RX_PARITY_EN
    , perr_o
`endif
  );

  modport slave (
    output ready_i,
    input  dat_o, valid_o, ferr_o, ovr_o
`ifdef SIA_RX_PARITY_EN
    , perr_o
`endif
  );

endinterface

// File: rtl/sia_sync.sv
// STAGES-deep flop synchroniser for an asynchronous pad input; RST_VAL is the
// idle level of the line so reset does not fabricate an edge.
module sia_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_reg;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ff_reg <= {STAGES{RST_VAL}};
    end else begin
      ff_reg <= {ff_reg[STAGES-2:0], d};
    end
  end

  assign q = ff_reg[STAGES-1];

endmodule

// File: rtl/sia_receiver_v2.sv
// SIA bit-serial receiver: synchronised RXD/RXC, start/stop framed FSM with
// edge resync, valid/ready output with overrun. Optional parity: SIA_RX_PARITY_EN.
module sia_receiver_v2
  import sia_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BAUD_WIDTH  = 32,
  parameter int BITS_WIDTH  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [BITS_WIDTH-1:0] bits_i,
  input  logic [BAUD_WIDTH-1:0] baud_i,
  input  logic                  eedd_i,
  input  logic                  eedc_i,
  input  logic                  msbf_i,
  input  logic                  rxd_i,
  input  logic                  rxc_i,
`ifdef SIA_RX_PARITY_EN
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
`endif
  output logic                  idle_o,
  output logic                  sample_to,
  sia_receiver_v2_if.master     rx
);

  localparam int NW = $clog2(DATA_WIDTH + 1);

  logic rxd_s, rxc_s, rxd_d_reg, rxc_d_reg;
  logic rxd_fall, resync;

  sia_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RXD_RST)) u_sync_rxd (
    .clk_i(clk_i), .reset_ni(reset_ni), .d(rxd_i), .q(rxd_s)
  );
  sia_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RXC_RST)) u_sync_rxc (
    .clk_i(clk_i), .reset_ni(reset_ni), .d(rxc_i), .q(rxc_s)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rxd_d_reg <= RXD_RST;
      rxc_d_reg <= RXC_RST;
    end else begin
      rxd_d_reg <= rxd_s;
      rxc_d_reg <= rxc_s;
    end
  end

  assign rxd_fall = rxd_d_reg & ~rxd_s;
  assign resync   = (eedd_i & (rxd_d_reg ^ rxd_s)) | (eedc_i & rxc_s & ~rxc_d_reg);

  state_t                state_reg, state_next;
  logic [BAUD_WIDTH-1:0] cnt_reg, cnt_next, baud_reg, baud_next;
  logic [NW-1:0]         n_reg, n_next, bitcnt_reg, bitcnt_next, n_in;
  logic                  msbf_reg, msbf_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next, dat_reg, dat_next, ins_mask;
  logic                  valid_reg, valid_next, ferr_reg, ferr_next, ovr_reg, ovr_next;
  logic                  sample, done;
`ifdef SIA_RX_PARITY_EN
  logic                  par_en_reg, par_en_next, par_odd_reg, par_odd_next;
  logic                  par_bit_reg, par_bit_next, perr_reg, perr_next;
`endif

  assign n_in     = (32'(bits_i) > DATA_WIDTH) ? NW'(DATA_WIDTH) : NW'(bits_i);
  // LSB-first bits enter at position N-1 so the word ends up right-justified
  assign ins_mask = DATA_WIDTH'(1) << (n_reg - 1'b1);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    baud_next   = baud_reg;
    n_next      = n_reg;
    bitcnt_next = bitcnt_reg;
    msbf_next   = msbf_reg;
    shift_next  = shift_reg;
    dat_next    = dat_reg;
    valid_next  = valid_reg;
    ferr_next   = ferr_reg;
    ovr_next    = ovr_reg;
    sample      = 1'b0;
    done        = 1'b0;
`ifdef SIA_RX_PARITY_EN
    par_en_next  = par_en_reg;
    par_odd_next = par_odd_reg;
    par_bit_next = par_bit_reg;
    perr_next    = perr_reg;
`endif

    if (state_reg == ST_IDLE) begin
      if (n_in != '0 && rxd_fall) begin
        state_next = ST_START;
        cnt_next   = baud_i >> 1;
        baud_next  = baud_i;
        n_next     = n_in;
        msbf_next  = msbf_i;
        shift_next = '0;
`ifdef SIA_RX_PARITY_EN
        par_en_next  = parity_en_i;
        par_odd_next = parity_odd_i;
`endif
      end
    end else if (resync) begin
      // a resync edge swallows any sample that would have fallen on this cycle
      cnt_next = baud_reg >> 1;
    end else if (cnt_reg == '0) begin
      sample   = 1'b1;
      cnt_next = baud_reg;
      case (state_reg)
        ST_START: begin
          if (rxd_s) begin
            state_next = ST_IDLE;
          end else begin
            state_next  = ST_DATA;
            bitcnt_next = n_reg;
          end
        end
        ST_DATA: begin
          if (msbf_reg) shift_next = {shift_reg[DATA_WIDTH-2:0], rxd_s};
          else          shift_next = (shift_reg >> 1) | (rxd_s ? ins_mask : '0);
          bitcnt_next = bitcnt_reg - 1'b1;
          if (bitcnt_reg == NW'(1)) begin
`ifdef SIA_RX_PARITY_EN
            state_next = par_en_reg ? ST_PARITY : ST_STOP;
`else
            state_next = ST_STOP;
`endif
          end
        end
`ifdef SIA_RX_PARITY_EN
        ST_PARITY: begin
          par_bit_next = rxd_s;
          state_next   = ST_STOP;
        end
`endif
        ST_STOP: begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end else begin
      cnt_next = cnt_reg - 1'b1;
    end

    if (done) begin
      dat_next   = shift_reg;
      valid_next = 1'b1;
      ferr_next  = ~rxd_s;
      ovr_next   = valid_reg & ~rx.ready_i;
`ifdef SIA_RX_PARITY_EN
      perr_next  = par_en_reg & ((^shift_reg ^ par_bit_reg) != par_odd_reg);
`endif
    end else if (valid_reg && rx.ready_i) begin
      valid_next = 1'b0;
      ferr_next  = 1'b0;
      ovr_next   = 1'b0;
`ifdef SIA_RX_PARITY_EN
      perr_next  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      baud_reg   <= '0;
      n_reg      <= '0;
      bitcnt_reg <= '0;
      msbf_reg   <= 1'b0;
      shift_reg  <= '0;
      dat_reg    <= '0;
      valid_reg  <= 1'b0;
      ferr_reg   <= 1'b0;
      ovr_reg    <= 1'b0;
`ifdef SIA_RX_PARITY_EN
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      par_bit_reg <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      baud_reg   <= baud_next;
      n_reg      <= n_next;
      bitcnt_reg <= bitcnt_next;
      msbf_reg   <= msbf_next;
      shift_reg  <= shift_next;
      dat_reg    <= dat_next;
      valid_reg  <= valid_next;
      ferr_reg   <= ferr_next;
      ovr_reg    <= ovr_next;
`ifdef SIA_RX_PARITY_EN
      par_en_reg  <= par_en_next;
      par_odd_reg <= par_odd_next;
      par_bit_reg <= par_bit_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  assign idle_o     = (state_reg == ST_IDLE);
  assign sample_to  = sample;
  assign rx.dat_o   = dat_reg;
  assign rx.valid_o = valid_reg;
  assign rx.ferr_o  = ferr_reg;
  assign rx.ovr_o   = ovr_reg;
`ifdef SIA_RX_PARITY_EN
  assign rx.perr_o  = perr_reg;
`endif

endmodule

// File: tb/tb_sia_receiver_v2.sv
// Self-checking bench for sia_receiver_v2: vector table, randomized frames against
// a frame-level model, and hand-written handshake/reset/resync sequences.
module tb_sia_receiver_v2;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [4:0]  bits = 5'd8;
  logic [31:0] baud = 32'd9;
  logic        eedd = 1'b0, eedc = 1'b0, msbf = 1'b0;
  logic        rxd = 1'b1, rxc = 1'b0;
  logic        idle, sample_to;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cycles = 0;

  typedef struct {
    logic [15:0] dat;
    logic        ferr;
    logic        ovr;
  } word_t;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    bit          msb_first;
    bit          stop_bit;
    int          baud_v;
    logic [15:0] exp_dat;
    bit          exp_ferr;
  } vec_t;

  word_t acc_q[$];
  int    samp_q[$];
  vec_t  tbl[7];

  always #5 clk = ~clk;

  sia_receiver_v2_if #(.DATA_WIDTH(16)) bus ();

  sia_receiver_v2 dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .bits_i   (bits),
    .baud_i   (baud),
    .eedd_i   (eedd),
    .eedc_i   (eedc),
    .msbf_i   (msbf),
    .rxd_i    (rxd),
    .rxc_i    (rxc),
`ifdef SIA_RX_PARITY_EN
    .parity_en_i  (1'b0),
    .parity_odd_i (1'b0),
`endif
    .idle_o   (idle),
    .sample_to(sample_to),
    .rx       (bus)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) valid_cycles++;
    if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1)
      acc_q.push_back('{bus.dat_o, bus.ferr_o, bus.ovr_o});
    if (sample_to === 1'b1) samp_q.push_back(cyc);
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // frame-level model: N is clamped to the data width, the word is the N line bits right-justified
  function automatic int model_n(input int b);
    return (b > 16) ? 16 : b;
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] w, input int n);
    logic [31:0] m;
    m = (32'd1 << n) - 32'd1;
    return 16'(32'(w) & m);
  endfunction

  task automatic send_frame(input logic [15:0] w, input int n, input bit mf,
                            input bit stopb, input int period);
    rxd = 1'b0;
    wait_cycles(period);
    for (int i = 0; i < n; i++) begin
      rxd = mf ? w[n-1-i] : w[i];
      wait_cycles(period);
    end
    rxd = stopb;
    wait_cycles(period);
    rxd = 1'b1;
    wait_cycles(period + 4);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    samp_q.delete();
    valid_cycles = 0;
  endtask

  task automatic run_frame(input string name, input logic [15:0] w, input int b,
                           input bit mf, input bit stopb, input int bd,
                           input logic [15:0] exp_dat, input bit exp_ferr);
    int    n, bad;
    word_t got;
    bits = 5'(b);
    baud = 32'(bd);
    msbf = mf;
    wait_cycles(2);
    clear_logs();
    n = model_n(b);
    send_frame(w, n, mf, stopb, bd + 1);
    wait_cycles(4);
    check({name, "/word_count"}, acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      got = acc_q.pop_front();
      check({name, "/dat"}, got.dat, exp_dat);
      check({name, "/ferr"}, got.ferr, exp_ferr);
      check({name, "/ovr"}, got.ovr, 0);
    end
    check({name, "/valid_cycles"}, valid_cycles, 1);
    check({name, "/samples"}, samp_q.size(), n + 2);
    bad = 0;
    for (int i = 1; i < samp_q.size(); i++)
      if (samp_q[i] - samp_q[i-1] != bd + 1) bad++;
    check({name, "/sample_spacing_bad"}, bad, 0);
  endtask

  initial begin
    int    bad;
    word_t got;

    tbl[0] = '{16'h00A5,  8, 1'b0, 1'b1, 9, 16'h00A5, 1'b0};
    tbl[1] = '{16'h00A5,  8, 1'b1, 1'b1, 9, 16'h00A5, 1'b0};
    tbl[2] = '{16'h00A5,  8, 1'b0, 1'b0, 9, 16'h00A5, 1'b1};
    tbl[3] = '{16'h1234, 20, 1'b0, 1'b1, 5, 16'h1234, 1'b0};
    tbl[4] = '{16'h00FF,  5, 1'b1, 1'b1, 3, 16'h001F, 1'b0};
    tbl[5] = '{16'h8001, 16, 1'b1, 1'b1, 2, 16'h8001, 1'b0};
    tbl[6] = '{16'h0003,  2, 1'b0, 1'b0, 1, 16'h0003, 1'b1};

    bus.ready_i = 1'b1;
    wait_cycles(3);
    check("reset/dat", bus.dat_o, 0);
    check("reset/valid", bus.valid_o, 0);
    check("reset/ferr", bus.ferr_o, 0);
    check("reset/ovr", bus.ovr_o, 0);
    check("reset/idle", idle, 1);
    check("reset/sample_to", sample_to, 0);
    reset_ni = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].word, tbl[i].nbits, tbl[i].msb_first,
                tbl[i].stop_bit, tbl[i].baud_v, tbl[i].exp_dat, tbl[i].exp_ferr);

    for (int i = 0; i < 12; i++) begin
      logic [15:0] w;
      int          b, bd;
      bit          mf, sb;
      w  = 16'($urandom);
      b  = $urandom_range(1, 20);
      bd = $urandom_range(1, 12);
      mf = 1'($urandom);
      sb = 1'($urandom);
      run_frame($sformatf("rnd%0d", i), w, b, mf, sb, bd, model_word(w, model_n(b)), !sb);
    end

    // false start: RXD low for only 3 cycles
    bits = 5'd8;
    baud = 32'd9;
    msbf = 1'b0;
    wait_cycles(2);
    clear_logs();
    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(3);
    check("false_start/in_start", idle, 0);
    wait_cycles(30);
    check("false_start/idle", idle, 1);
    check("false_start/valid_cycles", valid_cycles, 0);
    check("false_start/samples", samp_q.size(), 1);

    // overrun with ready low
    bus.ready_i = 1'b0;
    clear_logs();
    send_frame(16'h0011, 8, 1'b0, 1'b1, 10);
    wait_cycles(4);
    check("ovr/first_valid", bus.valid_o, 1);
    check("ovr/first_dat", bus.dat_o, 16'h0011);
    check("ovr/first_ovr", bus.ovr_o, 0);
    send_frame(16'h0022, 8, 1'b0, 1'b1, 10);
    wait_cycles(4);
    check("ovr/second_valid", bus.valid_o, 1);
    check("ovr/second_dat", bus.dat_o, 16'h0022);
    check("ovr/second_ovr", bus.ovr_o, 1);
    check("ovr/second_ferr", bus.ferr_o, 0);
    bus.ready_i = 1'b1;
    wait_cycles(1);
    check("ovr/cleared_valid", bus.valid_o, 0);
    check("ovr/cleared_ovr", bus.ovr_o, 0);
    check("ovr/accepted_count", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      got = acc_q.pop_front();
      check("ovr/accepted_dat", got.dat, 16'h0022);
      check("ovr/accepted_ovr", got.ovr, 1);
    end

    // receiver disabled
    bits = 5'd0;
    wait_cycles(2);
    clear_logs();
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      rxd = 1'($urandom);
      wait_cycles(1);
      if (idle !== 1'b1) bad++;
    end
    rxd = 1'b1;
    wait_cycles(5);
    check("disabled/non_idle_cycles", bad, 0);
    check("disabled/valid_cycles", valid_cycles, 0);
    check("disabled/samples", samp_q.size(), 0);

    // resync on RXD edges with bits arriving 3 cycles late each
    bits = 5'd8;
    baud = 32'd9;
    eedd = 1'b1;
    wait_cycles(2);
    clear_logs();
    send_frame(16'h0055, 8, 1'b0, 1'b1, 13);
    wait_cycles(4);
    eedd = 1'b0;
    check("resync/word_count", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      got = acc_q.pop_front();
      check("resync/dat", got.dat, 16'h0055);
      check("resync/ferr", got.ferr, 0);
    end
    check("resync/samples", samp_q.size(), 10);
    bad = 0;
    for (int i = 1; i < samp_q.size(); i++)
      if (samp_q[i] - samp_q[i-1] != 13) bad++;
    check("resync/sample_spacing_bad", bad, 0);

    // reset in the middle of DATA
    clear_logs();
    rxd = 1'b0;
    wait_cycles(10);
    rxd = 1'b1;
    wait_cycles(10);
    rxd = 1'b0;
    wait_cycles(5);
    check("midreset/busy", idle, 0);
    reset_ni = 1'b0;
    #1;
    check("midreset/dat", bus.dat_o, 0);
    check("midreset/valid", bus.valid_o, 0);
    check("midreset/ferr", bus.ferr_o, 0);
    check("midreset/ovr", bus.ovr_o, 0);
    check("midreset/idle", idle, 1);
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(3);
    reset_ni = 1'b1;
    wait_cycles(200);
    check("midreset/valid_cycles", valid_cycles, 0);
    check("midreset/words", acc_q.size(), 0);

    run_frame("after_reset", 16'h003C, 8, 1'b0, 1'b1, 9, 16'h003C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
